// File: rtl/mips_avalon_arbiter_if.sv
// Avalon-MM bus bundle shared by the arbiter's master and slave sides.
// The master modport drives a request; the slave modport answers with waitrequest/readdata.
interface mips_avalon_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic                    waitrequest;
  logic [DATA_WIDTH-1:0]   readdata;

  modport master (
    output address, read, write, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, read, write, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/mips_avalon_arbiter.sv
// Two-master (m0 = instruction fetch, m1 = data) to one-slave Avalon-MM arbiter, round-robin.
// Define MIPS_AVALON_ARB_FIXED_PRIO_EN to make m1 win every contended arbitration instead.
module mips_avalon_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter bit INIT_LAST  = 1'b1
) (
  input logic                   clk,
  input logic                   rst,
  mips_avalon_arbiter_if.slave  m0_if,
  mips_avalon_arbiter_if.slave  m1_if,
  mips_avalon_arbiter_if.master s_if
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;

`ifdef MIPS_AVALON_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_e;

  state_e                state_q;
  logic                  last_grant_q;
  logic                  req0;
  logic                  req1;
  logic                  pick_m1;
  logic [ADDR_WIDTH-1:0] s_address;
  logic                  s_read;
  logic                  s_write;
  logic [DATA_WIDTH-1:0] s_writedata;
  logic [BE_WIDTH-1:0]   s_byteenable;
  logic                  m0_wait;
  logic                  m1_wait;

  assign req0 = m0_if.read | m0_if.write;
  assign req1 = m1_if.read | m1_if.write;

  // Winner when both masters request at once: the one that was not served last.
  assign pick_m1 = FIXED_PRIO | ~last_grant_q;

  // NOTE: state lives in a clocked block with non-blocking assignments only, and the
  // reset is in the sensitivity list so the bus is released the instant rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= INIT_LAST;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0 && req1)  state_q <= pick_m1 ? GNT1 : GNT0;
          else if (req0)     state_q <= GNT0;
          else if (req1)     state_q <= GNT1;
        end
        GNT0: begin
          if (req0 && !s_if.waitrequest) begin
            last_grant_q <= 1'b0;
            state_q      <= req1 ? GNT1 : GNT0;
          end else if (!req0) begin
            state_q <= IDLE;
          end
        end
        GNT1: begin
          if (req1 && !s_if.waitrequest) begin
            last_grant_q <= 1'b1;
            state_q      <= (req0 && !FIXED_PRIO) ? GNT0 : GNT1;
          end else if (!req1) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Read+write together is illegal; the write wins so the slave never sees both.
  always_comb begin
    // NOTE: every output is given a default first so no path through the case infers a latch.
    s_address    = '0;
    s_read       = 1'b0;
    s_write      = 1'b0;
    s_writedata  = '0;
    s_byteenable = '0;
    m0_wait      = 1'b1;
    m1_wait      = 1'b1;
    unique case (state_q)
      GNT0: begin
        s_address    = m0_if.address;
        s_read       = m0_if.read & ~m0_if.write;
        s_write      = m0_if.write;
        s_writedata  = m0_if.writedata;
        s_byteenable = m0_if.byteenable;
        m0_wait      = s_if.waitrequest;
      end
      GNT1: begin
        s_address    = m1_if.address;
        s_read       = m1_if.read & ~m1_if.write;
        s_write      = m1_if.write;
        s_writedata  = m1_if.writedata;
        s_byteenable = m1_if.byteenable;
        m1_wait      = s_if.waitrequest;
      end
      default: ;
    endcase
  end

  assign s_if.address      = s_address;
  assign s_if.read         = s_read;
  assign s_if.write        = s_write;
  assign s_if.writedata    = s_writedata;
  assign s_if.byteenable   = s_byteenable;
  assign m0_if.waitrequest = m0_wait;
  assign m1_if.waitrequest = m1_wait;
  assign m0_if.readdata    = s_if.readdata;
  assign m1_if.readdata    = s_if.readdata;

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Self-checking bench for mips_avalon_arbiter: grant-vector table, slave-side scoreboard
// and hand-written multi-cycle sequences against a small RAM model with waitrequest delay.
`timescale 1ns/1ps
module tb_mips_avalon_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   other_low;

  mips_avalon_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_bus ();
  mips_avalon_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_bus ();
  mips_avalon_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_bus ();

  mips_avalon_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .INIT_LAST(1'b1)) dut (
    .clk   (clk),
    .rst   (rst),
    .m0_if (m0_bus),
    .m1_if (m1_bus),
    .s_if  (s_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: waitrequest held for rd_delay cycles of each request, or forever while stalled.
  logic        slave_stall;
  int unsigned rd_delay;
  int unsigned s_cnt;
  logic [31:0] mem [0:15];

  assign s_bus.waitrequest = slave_stall | ((s_bus.read | s_bus.write) && (s_cnt < rd_delay));
  assign s_bus.readdata    = mem[s_bus.address[5:2]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_cnt <= 0;
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + i;
    end else begin
      if ((s_bus.read | s_bus.write) && s_bus.waitrequest) s_cnt <= s_cnt + 1;
      else                                                 s_cnt <= 0;
      if (s_bus.write && !s_bus.waitrequest)
        for (int b = 0; b < 4; b++)
          if (s_bus.byteenable[b]) mem[s_bus.address[5:2]][8*b +: 8] <= s_bus.writedata[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard of slave-side transfers in the order they must be accepted.
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } exp_t;
  exp_t exp_q[$];

  always begin
    @(negedge clk);
    #4;
    if (!rst && (s_bus.read || s_bus.write) && !s_bus.waitrequest) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got transfer addr %h wr %b expected none", s_bus.address, s_bus.write);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_addr", s_bus.address, e.addr);
        check("sb_wr", {31'd0, s_bus.write}, {31'd0, e.wr});
        if (e.wr) begin
          check("sb_wdata", s_bus.writedata, e.wdata);
          check("sb_be", {28'd0, s_bus.byteenable}, {28'd0, e.be});
        end
      end
    end
  end

  task automatic drive(input int m, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (m == 0) begin
      m0_bus.read = rd; m0_bus.write = wr; m0_bus.address = a;
      m0_bus.writedata = d; m0_bus.byteenable = be;
    end else begin
      m1_bus.read = rd; m1_bus.write = wr; m1_bus.address = a;
      m1_bus.writedata = d; m1_bus.byteenable = be;
    end
  endtask

  task automatic idle(input int m);
    drive(m, 1'b0, 1'b0, 32'd0, 32'd0, 4'd0);
  endtask

  function automatic logic wait_of(input int m);
    return (m == 0) ? m0_bus.waitrequest : m1_bus.waitrequest;
  endfunction

  function automatic logic [31:0] rdata_of(input int m);
    return (m == 0) ? m0_bus.readdata : m1_bus.readdata;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge, request still driven.
  task automatic xfer(input int m, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      output logic [31:0] rdata, output int lat);
    drive(m, rd, wr, a, d, be);
    lat   = 0;
    rdata = '0;
    forever begin
      #4;
      if (!wait_of(m)) begin
        rdata = rdata_of(m);
        @(negedge clk);
        break;
      end
      if (m == 0 && !m1_bus.waitrequest) other_low++;
      if (lat >= 60) begin
        checks++;
        failures++;
        $display("FAIL xfer_timeout: master %0d still stalled after %0d cycles, expected completion", m, lat);
        @(negedge clk);
        break;
      end
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1;
    idle(0);
    idle(1);
    slave_stall = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("sb_drained", exp_q.size(), 0);
  endtask

  typedef struct {
    logic        m0_rd, m0_wr;
    logic [31:0] m0_a;
    logic        m1_rd, m1_wr;
    logic [31:0] m1_a;
    logic        exp_rd, exp_wr;
    logic [31:0] exp_a;
    logic        exp_w0, exp_w1;
  } vec_t;

  vec_t        vecs [6];
  logic [31:0] rdata, rdata0, rdata1;
  int          lat, lat0, lat1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; failures = 0; other_low = 0;
    rst = 1'b1; slave_stall = 1'b0; rd_delay = 2;
    idle(0);
    idle(1);

    // First grant after reset, zero-delay slave: s_* and waitrequests in the granted cycle.
    vecs[0] = '{1, 0, 32'hBFC0_0010, 0, 0, 32'h0,         1, 0, 32'hBFC0_0010, 0, 1};
    vecs[1] = '{0, 0, 32'h0,         0, 1, 32'hBFC0_0014, 0, 1, 32'hBFC0_0014, 1, 0};
`ifdef MIPS_AVALON_ARB_FIXED_PRIO_EN
    vecs[2] = '{1, 0, 32'hBFC0_0018, 1, 0, 32'hBFC0_001C, 1, 0, 32'hBFC0_001C, 1, 0};
`else
    vecs[2] = '{1, 0, 32'hBFC0_0018, 1, 0, 32'hBFC0_001C, 1, 0, 32'hBFC0_0018, 0, 1};
`endif
    vecs[3] = '{0, 0, 32'h0,         0, 0, 32'h0,         0, 0, 32'h0,         1, 1};
    vecs[4] = '{1, 1, 32'hBFC0_0020, 0, 0, 32'h0,         0, 1, 32'hBFC0_0020, 0, 1};
`ifdef MIPS_AVALON_ARB_FIXED_PRIO_EN
    vecs[5] = '{0, 1, 32'hBFC0_0024, 1, 0, 32'hBFC0_0028, 1, 0, 32'hBFC0_0028, 1, 0};
`else
    vecs[5] = '{0, 1, 32'hBFC0_0024, 1, 0, 32'hBFC0_0028, 0, 1, 32'hBFC0_0024, 0, 1};
`endif

    for (int i = 0; i < 6; i++) begin
      reset_dut();
      rd_delay = 0;
      drive(0, vecs[i].m0_rd, vecs[i].m0_wr, vecs[i].m0_a, 32'hC0DE_0000 + i, 4'hF);
      drive(1, vecs[i].m1_rd, vecs[i].m1_wr, vecs[i].m1_a, 32'hC0DE_0000 + i, 4'hF);
      if (vecs[i].exp_rd || vecs[i].exp_wr)
        exp_q.push_back('{vecs[i].exp_a, vecs[i].exp_wr, 32'hC0DE_0000 + i, 4'hF});
      #4;
      check($sformatf("vec%0d_idle_s_read", i),  {31'd0, s_bus.read},         32'd0);
      check($sformatf("vec%0d_idle_s_write", i), {31'd0, s_bus.write},        32'd0);
      check($sformatf("vec%0d_idle_s_addr", i),  s_bus.address,               32'd0);
      check($sformatf("vec%0d_idle_m0_wait", i), {31'd0, m0_bus.waitrequest}, 32'd1);
      check($sformatf("vec%0d_idle_m1_wait", i), {31'd0, m1_bus.waitrequest}, 32'd1);
      @(negedge clk);
      #4;
      check($sformatf("vec%0d_s_read", i),  {31'd0, s_bus.read},         {31'd0, vecs[i].exp_rd});
      check($sformatf("vec%0d_s_write", i), {31'd0, s_bus.write},        {31'd0, vecs[i].exp_wr});
      check($sformatf("vec%0d_s_addr", i),  s_bus.address,               vecs[i].exp_a);
      check($sformatf("vec%0d_m0_wait", i), {31'd0, m0_bus.waitrequest}, {31'd0, vecs[i].exp_w0});
      check($sformatf("vec%0d_m1_wait", i), {31'd0, m1_bus.waitrequest}, {31'd0, vecs[i].exp_w1});
      @(negedge clk);
      idle(0);
      idle(1);
      @(negedge clk);
    end

    // Single m0 read, slave delay 2: one cycle to grant, two stalled slave cycles.
    reset_dut();
    rd_delay  = 2;
    other_low = 0;
    exp_q.push_back('{32'hBFC0_0000, 1'b0, 32'd0, 4'd0});
    xfer(0, 1'b1, 1'b0, 32'hBFC0_0000, 32'd0, 4'hF, rdata, lat);
    idle(0);
    check("single_lat",      lat,       3);
    check("single_rdata",    rdata,     32'hA000_0000);
    check("single_m1_wait0", other_low, 0);

    // Contended reads straight after reset.
    reset_dut();
`ifdef MIPS_AVALON_ARB_FIXED_PRIO_EN
    exp_q.push_back('{32'hBFC0_0008, 1'b0, 32'd0, 4'd0});
    exp_q.push_back('{32'hBFC0_0004, 1'b0, 32'd0, 4'd0});
`else
    exp_q.push_back('{32'hBFC0_0004, 1'b0, 32'd0, 4'd0});
    exp_q.push_back('{32'hBFC0_0008, 1'b0, 32'd0, 4'd0});
`endif
    fork
      begin xfer(0, 1'b1, 1'b0, 32'hBFC0_0004, 32'd0, 4'hF, rdata0, lat0); idle(0); end
      begin xfer(1, 1'b1, 1'b0, 32'hBFC0_0008, 32'd0, 4'hF, rdata1, lat1); idle(1); end
    join
    check("contend_m0_rdata", rdata0, 32'hA000_0001);
    check("contend_m1_rdata", rdata1, 32'hA000_0002);
`ifdef MIPS_AVALON_ARB_FIXED_PRIO_EN
    check("contend_m1_lat", lat1, 3);
    check("contend_m0_lat", lat0, 8);
`else
    check("contend_m0_lat", lat0, 3);
    check("contend_m1_lat", lat1, 6);
`endif

    // Continuous requests from both masters, three back-to-back transfers each.
    reset_dut();
    for (int k = 0; k < 3; k++) begin
`ifdef MIPS_AVALON_ARB_FIXED_PRIO_EN
      exp_q.push_back('{32'hBFC0_0020 + 4 * k, 1'b0, 32'd0, 4'd0});
`else
      exp_q.push_back('{32'hBFC0_0010 + 4 * k, 1'b0, 32'd0, 4'd0});
      exp_q.push_back('{32'hBFC0_0020 + 4 * k, 1'b0, 32'd0, 4'd0});
`endif
    end
`ifdef MIPS_AVALON_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 3; k++) exp_q.push_back('{32'hBFC0_0010 + 4 * k, 1'b0, 32'd0, 4'd0});
`endif
    fork
      begin
        logic [31:0] rd_a;
        int          l_a;
        for (int k = 0; k < 3; k++) begin
          xfer(0, 1'b1, 1'b0, 32'hBFC0_0010 + 4 * k, 32'd0, 4'hF, rd_a, l_a);
          check("stream_m0_rdata", rd_a, 32'hA000_0004 + k);
        end
        idle(0);
      end
      begin
        logic [31:0] rd_b;
        int          l_b;
        for (int k = 0; k < 3; k++) begin
          xfer(1, 1'b1, 1'b0, 32'hBFC0_0020 + 4 * k, 32'd0, 4'hF, rd_b, l_b);
          check("stream_m1_rdata", rd_b, 32'hA000_0008 + k);
        end
        idle(1);
      end
    join

    // Partial-byte write from m1, then m0 reads the merged word back.
    reset_dut();
    exp_q.push_back('{32'hBFC0_0004, 1'b1, 32'h1111_1111, 4'b0110});
    xfer(1, 1'b0, 1'b1, 32'hBFC0_0004, 32'h1111_1111, 4'b0110, rdata, lat);
    idle(1);
    exp_q.push_back('{32'hBFC0_0004, 1'b0, 32'd0, 4'd0});
    xfer(0, 1'b1, 1'b0, 32'hBFC0_0004, 32'd0, 4'hF, rdata, lat);
    idle(0);
    check("be_merge_rdata", rdata, 32'hA011_1101);

    // Reset while m1's write is stalled by the slave.
    reset_dut();
    slave_stall = 1'b1;
    drive(1, 1'b0, 1'b1, 32'hBFC0_000C, 32'hDEAD_BEEF, 4'hF);
    @(negedge clk);
    @(negedge clk);
    #2;
    check("rst_pre_s_write", {31'd0, s_bus.write}, 32'd1);
    rst = 1'b1;
    #1;
    check("rst_s_write",  {31'd0, s_bus.write},        32'd0);
    check("rst_s_read",   {31'd0, s_bus.read},         32'd0);
    check("rst_s_addr",   s_bus.address,               32'd0);
    check("rst_m0_wait",  {31'd0, m0_bus.waitrequest}, 32'd1);
    check("rst_m1_wait",  {31'd0, m1_bus.waitrequest}, 32'd1);
    @(negedge clk);
    #2;
    check("rst_hold_m1_wait", {31'd0, m1_bus.waitrequest}, 32'd1);
    @(negedge clk);
    idle(1);
    rst = 1'b0;
    slave_stall = 1'b0;
    #4;
    check("rst_after_s_write", {31'd0, s_bus.write},        32'd0);
    check("rst_after_m0_wait", {31'd0, m0_bus.waitrequest}, 32'd1);
    @(negedge clk);
    exp_q.push_back('{32'hBFC0_0000, 1'b0, 32'd0, 4'd0});
    xfer(0, 1'b1, 1'b0, 32'hBFC0_0000, 32'd0, 4'hF, rdata, lat);
    idle(0);
    check("rst_after_lat",   lat,   3);
    check("rst_after_rdata", rdata, 32'hA000_0000);

    // Illegal read+write from m0, then m0 aborts while granted and m1 is waiting.
    reset_dut();
    drive(0, 1'b1, 1'b1, 32'hBFC0_0030, 32'h55AA_55AA, 4'hF);
    @(negedge clk);
    #4;
    check("rdwr_s_write", {31'd0, s_bus.write},        32'd1);
    check("rdwr_s_read",  {31'd0, s_bus.read},         32'd0);
    check("rdwr_s_addr",  s_bus.address,               32'hBFC0_0030);
    check("rdwr_m0_wait", {31'd0, m0_bus.waitrequest}, 32'd1);
    @(negedge clk);
    idle(0);
    exp_q.push_back('{32'hBFC0_0034, 1'b0, 32'd0, 4'd0});
    fork
      xfer(1, 1'b1, 1'b0, 32'hBFC0_0034, 32'd0, 4'hF, rdata, lat);
      begin
        #4;
        check("abort_s_write", {31'd0, s_bus.write}, 32'd0);
        check("abort_s_read",  {31'd0, s_bus.read},  32'd0);
        @(negedge clk);
        #4;
        check("abort_idle_s_read",  {31'd0, s_bus.read},         32'd0);
        check("abort_idle_m1_wait", {31'd0, m1_bus.waitrequest}, 32'd1);
      end
    join
    idle(1);
    check("abort_m1_lat",   lat,   4);
    check("abort_m1_rdata", rdata, 32'hA000_000D);

    @(negedge clk);
    @(negedge clk);
    check("sb_final_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
